// File: rtl/m_pcpi_frontend.sv
// m_pcpi_frontend: PCPI front end that decodes RV32M instructions and hands them to an M unit.
// Optional single-entry result cache is built when M_RESULT_CACHE_EN is defined.
module m_pcpi_frontend (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_m_insn(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
  endfunction

  state_t      state_r;
  logic        abort_r;
  logic        decode_hit_s;
  logic        issue_abort_s;
  logic        wait_abort_s;
  logic        capture_s;
  logic        complete_s;
  logic        cache_hit_s;
  logic        cache_wr_s;
  logic [31:0] cache_rd_s;

  assign decode_hit_s  = is_m_insn(pcpi_insn);
  assign issue_abort_s = (state_r == ST_ISSUE) && !pcpi_valid;
  assign wait_abort_s  = (state_r == ST_WAIT) && !pcpi_valid;
  assign capture_s     = (state_r == ST_WAIT) && m_ready;
  // A result is only delivered if the core never let go of the request.
  assign complete_s    = capture_s && pcpi_valid && !abort_r;

  // The issue strobe has to track m_busy in the same cycle, so it is decoded from state.
  assign m_valid = (state_r == ST_ISSUE) && pcpi_valid && !m_busy;

`ifdef M_RESULT_CACHE_EN
  logic        cache_valid_r;
  logic [2:0]  cache_funct3_r;
  logic [31:0] cache_rs1_r;
  logic [31:0] cache_rs2_r;
  logic        cache_wr_r;
  logic [31:0] cache_rd_r;

  assign cache_hit_s = cache_valid_r &&
                       (pcpi_insn[14:12] == cache_funct3_r) &&
                       (pcpi_rs1 == cache_rs1_r) &&
                       (pcpi_rs2 == cache_rs2_r);
  assign cache_wr_s  = cache_wr_r;
  assign cache_rd_s  = cache_rd_r;

  // Result cache: filled by each completed M-unit response, dropped on any abort.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cache_valid_r  <= 1'b0;
      cache_funct3_r <= 3'd0;
      cache_rs1_r    <= 32'd0;
      cache_rs2_r    <= 32'd0;
      cache_wr_r     <= 1'b0;
      cache_rd_r     <= 32'd0;
    end else if (issue_abort_s || wait_abort_s) begin
      cache_valid_r  <= 1'b0;
    end else if (complete_s) begin
      cache_valid_r  <= 1'b1;
      cache_funct3_r <= m_instruction[14:12];
      cache_rs1_r    <= m_rs1;
      cache_rs2_r    <= m_rs2;
      cache_wr_r     <= m_wr;
      cache_rd_r     <= m_rd;
    end else begin
      cache_valid_r  <= cache_valid_r;
    end
  end
`else
  assign cache_hit_s = 1'b0;
  assign cache_wr_s  = 1'b0;
  assign cache_rd_s  = 32'd0;
`endif

  // Request FSM; the pcpi outputs and latched request fields are all registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      abort_r       <= 1'b0;
      pcpi_wr       <= 1'b0;
      pcpi_rd       <= 32'd0;
      pcpi_wait     <= 1'b0;
      pcpi_ready    <= 1'b0;
      m_instruction <= 32'd0;
      m_rs1         <= 32'd0;
      m_rs2         <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pcpi_valid && decode_hit_s) begin
            m_instruction <= pcpi_insn;
            m_rs1         <= pcpi_rs1;
            m_rs2         <= pcpi_rs2;
            abort_r       <= 1'b0;
            if (cache_hit_s) begin
              state_r    <= ST_RESP;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= cache_wr_s;
              pcpi_rd    <= cache_rd_s;
            end else begin
              state_r   <= ST_ISSUE;
              pcpi_wait <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (issue_abort_s) begin
            state_r   <= ST_IDLE;
            pcpi_wait <= 1'b0;
          end else if (!m_busy) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (capture_s) begin
            pcpi_wait <= 1'b0;
            abort_r   <= 1'b0;
            if (complete_s) begin
              state_r    <= ST_RESP;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= m_wr;
              pcpi_rd    <= m_rd;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (wait_abort_s) begin
            abort_r <= 1'b1;
          end
        end
        ST_RESP: begin
          state_r    <= ST_IDLE;
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          pcpi_rd    <= 32'd0;
        end
        default: begin
          state_r    <= ST_IDLE;
          abort_r    <= 1'b0;
          pcpi_wait  <= 1'b0;
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          pcpi_rd    <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_pcpi_frontend.sv
// tb_m_pcpi_frontend: directed scenarios plus randomized traffic against a transaction-level model.
module tb_m_pcpi_frontend;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        m_valid;
  logic [31:0] m_instruction;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  logic        m_wr;
  logic [31:0] m_rd;
  logic        m_busy;
  logic        m_ready;

`ifdef M_RESULT_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_RESP  = 3;

  m_pcpi_frontend dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int vec_count = 0;
  int err_count = 0;
  int mv_cnt    = 0;
  int rdy_cnt   = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_m(input logic [31:0] w);
    return (w[6:0] == 7'h33) && (w[31:25] == 7'h01);
  endfunction

  // Transaction-level reference: request phase, latched request, captured result, cache entry.
  int          ph = PH_IDLE;
  logic [31:0] mdl_insn = 32'd0, mdl_rs1 = 32'd0, mdl_rs2 = 32'd0, mdl_rd = 32'd0;
  logic        mdl_wr = 1'b0, mdl_abort = 1'b0;
  logic        c_valid = 1'b0, c_wr = 1'b0;
  logic [2:0]  c_f3 = 3'd0;
  logic [31:0] c_rs1 = 32'd0, c_rs2 = 32'd0, c_rd = 32'd0;

  always @(negedge clk) begin
    if (m_valid === 1'b1) mv_cnt++;
    if (pcpi_ready === 1'b1) rdy_cnt++;
  end

  // Compare process: inputs are stable here and are exactly what the next rising edge samples.
  always @(negedge clk) begin
    if (!resetn) begin
      ph = PH_IDLE; mdl_abort = 1'b0; c_valid = 1'b0;
      mdl_insn = 32'd0; mdl_rs1 = 32'd0; mdl_rs2 = 32'd0; mdl_rd = 32'd0; mdl_wr = 1'b0;
    end
    chk1 ("pcpi_wait",  pcpi_wait,  (ph == PH_ISSUE) || (ph == PH_WAIT));
    chk1 ("pcpi_ready", pcpi_ready, ph == PH_RESP);
    chk1 ("pcpi_wr",    pcpi_wr,    (ph == PH_RESP) ? mdl_wr : 1'b0);
    chk32("pcpi_rd",    pcpi_rd,    (ph == PH_RESP) ? mdl_rd : 32'd0);
    chk1 ("m_valid",    m_valid,    (ph == PH_ISSUE) && pcpi_valid && !m_busy);
    chk32("m_instruction", m_instruction, mdl_insn);
    chk32("m_rs1",      m_rs1,      mdl_rs1);
    chk32("m_rs2",      m_rs2,      mdl_rs2);
    if (resetn) begin
      case (ph)
        PH_IDLE: if (pcpi_valid && is_m(pcpi_insn)) begin
          mdl_insn = pcpi_insn; mdl_rs1 = pcpi_rs1; mdl_rs2 = pcpi_rs2; mdl_abort = 1'b0;
          if (CACHE_ON && c_valid && pcpi_insn[14:12] == c_f3 && pcpi_rs1 == c_rs1 && pcpi_rs2 == c_rs2) begin
            ph = PH_RESP; mdl_wr = c_wr; mdl_rd = c_rd;
          end else begin
            ph = PH_ISSUE;
          end
        end
        PH_ISSUE: begin
          if (!pcpi_valid) begin ph = PH_IDLE; c_valid = 1'b0; end
          else if (!m_busy) ph = PH_WAIT;
        end
        PH_WAIT: begin
          if (!pcpi_valid) begin mdl_abort = 1'b1; c_valid = 1'b0; end
          if (m_ready) begin
            if (mdl_abort) ph = PH_IDLE;
            else begin
              ph = PH_RESP; mdl_wr = m_wr; mdl_rd = m_rd;
              c_valid = 1'b1; c_f3 = mdl_insn[14:12]; c_rs1 = mdl_rs1; c_rs2 = mdl_rs2;
              c_wr = m_wr; c_rd = m_rd;
            end
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic request(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
  endtask

  task automatic m_resp(input logic rdy, input logic wr, input logic [31:0] rd);
    m_ready = rdy; m_wr = wr; m_rd = rd;
  endtask

  logic [31:0] pool [4] = '{32'd0, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
  int          mv0, rdy0;
  logic        saw_rdy;
  logic [31:0] w;

  initial begin
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'd0; pcpi_rs1 = 32'd0; pcpi_rs2 = 32'd0;
    m_wr = 1'b0; m_rd = 32'd0; m_busy = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    look();
    chk1("rst_pcpi_wait", pcpi_wait, 1'b0);
    chk32("rst_m_rs1", m_rs1, 32'd0);
    step(); resetn = 1'b1;
    step();

    // MUL 7*6 with a three-cycle M unit
    mv0 = mv_cnt; rdy0 = rdy_cnt;
    request(32'h02B5_0533, 32'd7, 32'd6);
    step(); look();
    chk1("mul_mvalid_n1", m_valid, 1'b1);
    chk1("mul_wait_n1", pcpi_wait, 1'b1);
    chk32("mul_m_rs2", m_rs2, 32'd6);
    step(); step(); look();
    chk1("mul_wait_w2", pcpi_wait, 1'b1);
    step(); m_resp(1'b1, 1'b1, 32'd42);
    step(); m_resp(1'b0, 1'b0, 32'd0); look();
    chk1("mul_ready", pcpi_ready, 1'b1);
    chk32("mul_rd", pcpi_rd, 32'd42);
    chk1("mul_wr", pcpi_wr, 1'b1);
    chk1("mul_wait_resp", pcpi_wait, 1'b0);
    step(); pcpi_valid = 1'b0;
    step();
    chk32("mul_mvalid_pulses", 32'(mv_cnt - mv0), 32'd1);
    chk32("mul_ready_pulses", 32'(rdy_cnt - rdy0), 32'd1);

    // ADD held for 20 cycles is ignored
    request(32'h00B5_0533, 32'd1, 32'd2);
    for (int i = 0; i < 20; i++) begin
      look();
      chk1("add_wait", pcpi_wait, 1'b0);
      chk1("add_ready", pcpi_ready, 1'b0);
      chk1("add_mvalid", m_valid, 1'b0);
      step();
    end
    pcpi_valid = 1'b0;
    step();

    // Repeat of MUL 7*6
    mv0 = mv_cnt;
    request(32'h02B5_0533, 32'd7, 32'd6);
    step(); look();
    if (CACHE_ON) begin
      chk1("rep_ready_n1", pcpi_ready, 1'b1);
      chk32("rep_rd_n1", pcpi_rd, 32'd42);
      chk1("rep_wait_n1", pcpi_wait, 1'b0);
      step(); pcpi_valid = 1'b0;
    end else begin
      chk1("rep_ready_n1", pcpi_ready, 1'b0);
      chk1("rep_wait_n1", pcpi_wait, 1'b1);
      step(); m_resp(1'b1, 1'b1, 32'd42);
      step(); m_resp(1'b0, 1'b0, 32'd0); look();
      chk32("rep_rd", pcpi_rd, 32'd42);
      step(); pcpi_valid = 1'b0;
    end
    step();
    chk32("rep_mvalid_pulses", 32'(mv_cnt - mv0), CACHE_ON ? 32'd0 : 32'd1);

    // DIV by zero with the M unit busy for four cycles
    mv0 = mv_cnt;
    request(32'h02B5_4533, 32'd100, 32'd0); m_busy = 1'b1;
    step(); look();
    chk1("div_mvalid_busy1", m_valid, 1'b0);
    chk1("div_wait_busy1", pcpi_wait, 1'b1);
    step(); step(); look();
    chk1("div_mvalid_busy3", m_valid, 1'b0);
    step(); m_busy = 1'b0; look();
    chk1("div_mvalid_free", m_valid, 1'b1);
    step(); m_resp(1'b1, 1'b1, 32'hFFFF_FFFF);
    step(); m_resp(1'b0, 1'b0, 32'd0); look();
    chk1("div_ready", pcpi_ready, 1'b1);
    chk32("div_rd", pcpi_rd, 32'hFFFF_FFFF);
    step(); pcpi_valid = 1'b0;
    step();
    chk32("div_mvalid_pulses", 32'(mv_cnt - mv0), 32'd1);

    // Core drops the request two cycles into WAIT
    rdy0 = rdy_cnt;
    request(32'h02B5_0533, 32'd3, 32'd5);
    step(); step(); step(); pcpi_valid = 1'b0;
    step(); look();
    chk1("abt_wait_held", pcpi_wait, 1'b1);
    m_resp(1'b1, 1'b1, 32'd15);
    step(); m_resp(1'b0, 1'b0, 32'd0); look();
    chk1("abt_wait_idle", pcpi_wait, 1'b0);
    step();
    chk32("abt_ready_pulses", 32'(rdy_cnt - rdy0), 32'd0);
    mv0 = mv_cnt;
    request(32'h02B5_0533, 32'd3, 32'd5);
    step(); look();
    chk1("abt_next_mvalid", m_valid, 1'b1);
    step(); m_resp(1'b1, 1'b1, 32'd15);
    step(); m_resp(1'b0, 1'b0, 32'd0); look();
    chk1("abt_next_ready", pcpi_ready, 1'b1);
    chk32("abt_next_rd", pcpi_rd, 32'd15);
    step(); pcpi_valid = 1'b0;
    step();

    // Reset pulse in WAIT followed by a late m_ready
    rdy0 = rdy_cnt;
    request(32'h02B5_0533, 32'd9, 32'd9);
    step(); step(); step(); resetn = 1'b0; look();
    chk1("rstw_wait", pcpi_wait, 1'b0);
    chk32("rstw_m_insn", m_instruction, 32'd0);
    chk32("rstw_m_rs1", m_rs1, 32'd0);
    step(); resetn = 1'b1; pcpi_valid = 1'b0;
    step(); m_resp(1'b1, 1'b1, 32'd81);
    step(); m_resp(1'b0, 1'b0, 32'd0); look();
    chk1("rstw_ready", pcpi_ready, 1'b0);
    chk1("rstw_wait_after", pcpi_wait, 1'b0);
    step();
    chk32("rstw_ready_pulses", 32'(rdy_cnt - rdy0), 32'd0);

    // Randomized traffic; the compare process checks every cycle
    for (int cyc = 0; cyc < 4000; cyc++) begin
      look();
      saw_rdy = pcpi_ready;
      step();
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 299) == 0) resetn = 1'b0;
      if (pcpi_valid) begin
        if (saw_rdy || $urandom_range(0, 39) == 0 || (!is_m(pcpi_insn) && $urandom_range(0, 4) == 0))
          pcpi_valid = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        w = $urandom;
        w[6:0] = 7'h33; w[31:25] = 7'h01; w[14:12] = 3'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0: w[25] = 1'b0;
          1: w[6:0] = 7'h13;
          default: w[0] = 1'b1;
        endcase
        pcpi_valid = 1'b1; pcpi_insn = w;
        pcpi_rs1 = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 32'($urandom);
        pcpi_rs2 = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : 32'($urandom);
      end
      m_busy  = ($urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 3) == 0);
      m_wr    = 1'($urandom_range(0, 1));
      m_rd    = $urandom;
    end

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
